// File: rtl/fir_tap_loader.sv
// fir_tap_loader
//   Streams a block of complex FIR coefficients from an upstream valid/ready
//   source into a compute tile. Each accepted tap word is re-issued one cycle
//   later as a tap_valid strobe. Its tap_count index counts down from num-1
//   to 0. A protocol violation sets a sticky err flag: a bad tap count, s_last
//   arriving early, or s_last missing on the final tap.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   start, num                load request and tap count (1..MAX_TAPS)
//   s_valid/s_ready           upstream handshake
//   s_data_r/s_data_i/s_last  upstream tap word and end-of-block marker
//   tap_valid                 one-cycle strobe per issued tap
//   tap_data_r/tap_data_i     registered coefficient (held between strobes)
//   tap_count                 tap index for the current strobe (held)
//   busy                      high whenever the loader is not idle
//   done                      pulse coincident with the final tap strobe
//   err                       sticky protocol-error flag, cleared by rst only
module fir_tap_loader #(
  parameter int DATA_W   = 16,
  parameter int MAX_TAPS = 32,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W:0]    num,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data_r,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data_r,
  output logic [DATA_W-1:0] tap_data_i,
  output logic [CNT_W-1:0]  tap_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W:0] MAX_NUM = (CNT_W+1)'(MAX_TAPS);
  localparam logic [CNT_W:0] ONE_NUM = (CNT_W+1)'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                tap_valid_q, tap_valid_d;
  logic [DATA_W-1:0]   tap_data_r_q, tap_data_r_d;
  logic [DATA_W-1:0]   tap_data_i_q, tap_data_i_d;
  logic [CNT_W-1:0]    tap_count_q, tap_count_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W:0]      num_m1;
  logic                beat;

  // num_m1 always fits in CNT_W bits when num is legal (num <= MAX_TAPS).
  assign num_m1 = num - ONE_NUM;

  // Ready depends on state only, so upstream may wait on s_ready safely.
  assign s_ready = (state_q != IDLE);
  assign busy    = (state_q != IDLE);
  assign beat    = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tap_valid_d  = 1'b0;
    tap_data_r_d = tap_data_r_q;
    tap_data_i_d = tap_data_i_q;
    tap_count_d  = tap_count_q;
    done_d       = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((num == '0) || (num > MAX_NUM)) begin
            err_d = 1'b1;
          end else begin
            idx_d   = num_m1[CNT_W-1:0];
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (beat) begin
          tap_valid_d  = 1'b1;
          tap_data_r_d = s_data_r;
          tap_data_i_d = s_data_i;
          tap_count_d  = idx_q;
          if (idx_q == '0) begin
            if (s_last) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              // Upstream still has words for this block: swallow them.
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else begin
            idx_d = idx_q - 1'b1;
            if (s_last) begin
              // Block ended early; the short load is abandoned.
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      DRAIN: begin
        if (beat && s_last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tap_valid_q  <= 1'b0;
      tap_data_r_q <= '0;
      tap_data_i_q <= '0;
      tap_count_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tap_valid_q  <= tap_valid_d;
      tap_data_r_q <= tap_data_r_d;
      tap_data_i_q <= tap_data_i_d;
      tap_count_q  <= tap_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign tap_valid  = tap_valid_q;
  assign tap_data_r = tap_data_r_q;
  assign tap_data_i = tap_data_i_q;
  assign tap_count  = tap_count_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Testbench for fir_tap_loader: directed stimulus pushes expected taps into a
// scoreboard queue; a negedge monitor pops and compares each tap strobe.
module tb_fir_tap_loader;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W:0]    num;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data_r;
  logic [DATA_W-1:0] s_data_i;
  logic              s_last;
  logic              tap_valid;
  logic [DATA_W-1:0] tap_data_r;
  logic [DATA_W-1:0] tap_data_i;
  logic [CNT_W-1:0]  tap_count;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
    logic              dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  fir_tap_loader #(.DATA_W(DATA_W), .MAX_TAPS(32), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num        (num),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data_r   (s_data_r),
    .s_data_i   (s_data_i),
    .s_last     (s_last),
    .tap_valid  (tap_valid),
    .tap_data_r (tap_data_r),
    .tap_data_i (tap_data_i),
    .tap_count  (tap_count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Monitor: every tap strobe must match the head of the scoreboard; done
  // must never appear without a tap strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tap_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tap: got cnt=%0d r=%0d i=%0d done=%0d, required no tap",
                   tap_count, tap_data_r, tap_data_i, done);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (tap_count !== e.cnt || tap_data_r !== e.r || tap_data_i !== e.i || done !== e.dn) begin
            errors++;
            $display("FAIL tap: got cnt=%0d r=%0d i=%0d done=%0d, required cnt=%0d r=%0d i=%0d done=%0d",
                     tap_count, tap_data_r, tap_data_i, done, e.cnt, e.r, e.i, e.dn);
          end else begin
            $display("tap ok: cnt=%0d r=%0d i=%0d done=%0d", tap_count, tap_data_r, tap_data_i, done);
          end
        end
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL stray_done: got done=%0d, required 0 with tap_valid=0", done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check ok: %s = %0d", name, act);
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num   = (CNT_W+1)'(n);
    tick();
    start = 1'b0;
    num   = '0;
  endtask

  // One accepted beat; when tap is set, the expected strobe is queued first.
  task automatic beat(input int r, input int i, input bit last,
                      input bit tap, input int cnt, input bit dn);
    exp_t e;
    s_valid  = 1'b1;
    s_data_r = DATA_W'(r);
    s_data_i = DATA_W'(i);
    s_last   = last;
    if (tap) begin
      e.cnt = CNT_W'(cnt);
      e.r   = DATA_W'(r);
      e.i   = DATA_W'(i);
      e.dn  = dn;
      exp_q.push_back(e);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic gap();
    s_valid = 1'b0;
    tick();
  endtask

  task automatic drained(input string name);
    tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num = '0;
    s_valid = 1'b0; s_data_r = '0; s_data_i = '0; s_last = 1'b0;
    tick();
    tick();
    check("rst_tap_valid", 32'(tap_valid), 0);
    check("rst_tap_data_r", 32'(tap_data_r), 0);
    check("rst_tap_count", 32'(tap_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Six back-to-back beats, counts 5..0, done with the last.
    do_start(6);
    check("load_s_ready", 32'(s_ready), 1);
    beat(6, 0, 0, 1, 5, 0);
    beat(5, 0, 0, 1, 4, 0);
    beat(4, 0, 0, 1, 3, 0);
    beat(3, 0, 0, 1, 2, 0);
    beat(2, 0, 0, 1, 1, 0);
    beat(1, 0, 1, 1, 0, 1);
    check("t6_busy_after", 32'(busy), 0);
    drained("t6_drained");
    check("t6_err", 32'(err), 0);

    // Gapped stream of four; a start during LOAD must be ignored.
    do_start(4);
    beat(10, 100, 0, 1, 3, 0);
    start = 1'b1; num = '0;
    gap();
    start = 1'b0;
    check("gap_hold_r", 32'(tap_data_r), 10);
    check("gap_hold_cnt", 32'(tap_count), 3);
    beat(11, 101, 0, 1, 2, 0);
    gap();
    beat(12, 102, 0, 1, 1, 0);
    gap();
    beat(13, 103, 1, 1, 0, 1);
    drained("t4_drained");
    check("t4_err", 32'(err), 0);

    // Early s_last: taps 2 and 1 only, err set, idle immediately.
    do_start(3);
    beat(20, 1, 0, 1, 2, 0);
    beat(21, 2, 1, 1, 1, 0);
    check("early_busy", 32'(busy), 0);
    check("early_err", 32'(err), 1);
    drained("early_drained");

    // Missing s_last: two taps, then two discarded beats in DRAIN.
    do_start(2);
    beat(30, 3, 0, 1, 1, 0);
    beat(31, 4, 0, 1, 0, 0);
    check("drain_busy", 32'(busy), 1);
    beat(32, 5, 0, 0, 0, 0);
    check("drain_ready", 32'(s_ready), 1);
    beat(33, 6, 1, 0, 0, 0);
    check("drain_idle", 32'(busy), 0);
    check("drain_err", 32'(err), 1);
    drained("drain_drained");

    // Illegal tap counts after a clean reset, then the full 32-tap load.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("clr_err", 32'(err), 0);
    do_start(0);
    check("num0_err", 32'(err), 1);
    check("num0_busy", 32'(busy), 0);
    do_start(33);
    check("num33_busy", 32'(busy), 0);
    do_start(32);
    for (int k = 0; k < 32; k++) begin
      beat(200 + k, k, (k == 31), 1, 31 - k, (k == 31));
    end
    drained("t32_drained");
    check("t32_err_sticky", 32'(err), 1);

    // Reset mid-load: everything clears, then a fresh load completes.
    do_start(6);
    beat(40, 7, 0, 1, 5, 0);
    beat(41, 8, 0, 1, 4, 0);
    rst = 1'b1;
    s_valid = 1'b1; s_data_r = 16'd99; s_last = 1'b0;
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    check("mid_rst_tap_valid", 32'(tap_valid), 0);
    check("mid_rst_tap_data_r", 32'(tap_data_r), 0);
    check("mid_rst_tap_data_i", 32'(tap_data_i), 0);
    check("mid_rst_tap_count", 32'(tap_count), 0);
    check("mid_rst_s_ready", 32'(s_ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_err", 32'(err), 0);
    do_start(6);
    for (int k = 0; k < 6; k++) begin
      beat(50 + k, 60 + k, (k == 5), 1, 5 - k, (k == 5));
    end
    drained("fresh_drained");
    check("fresh_err", 32'(err), 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_loader.md
FIR_TAP_LOADER -- requirements
Module: fir_tap_loader

Parameters
REQ-001 SHALL have parameter DATA_W, default 16; width of each of data_r and data_i.
REQ-002 SHALL have parameter MAX_TAPS, default 32; the largest legal tap count.
REQ-003 SHALL have parameter CNT_W, default 5; CNT_W = clog2(MAX_TAPS).

Interface
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a tap load.
REQ-007 num  in  CNT_W+1  number of taps to load; sampled when start is accepted.
REQ-008 s_valid  in  1  upstream tap word valid.
REQ-009 s_ready  out  1  loader accepts a tap word.
REQ-010 s_data_r, s_data_i  in  DATA_W each  tap coefficient, real and imaginary.
REQ-011 s_last  in  1  marks the final upstream tap word.
REQ-012 tap_valid  out  1  tap-load strobe to the compute tile.
REQ-013 tap_data_r, tap_data_i  out  DATA_W each  registered coefficient.
REQ-014 tap_count  out  CNT_W  tap index for the current strobe.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when a load completes.
REQ-017 err  out  1  sticky protocol-error flag.

Function
REQ-018 SHALL implement the states IDLE, LOAD and DRAIN.
REQ-019 In IDLE, a start with 1 <= num <= MAX_TAPS SHALL load idx = num-1 and move to LOAD on the next edge.
REQ-020 In IDLE, a start with num = 0 or num > MAX_TAPS SHALL set err, stay in IDLE, and produce no done pulse.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 s_ready SHALL equal 1 in LOAD and DRAIN and 0 in IDLE; it SHALL be combinational from the state only, never from s_valid.
REQ-023 A beat SHALL be accepted on any edge where s_valid and s_ready are both high.
REQ-024 For a beat accepted in LOAD, the next cycle SHALL have tap_valid=1, tap_data equal to the beat's data, and tap_count = idx; latency is 1 cycle.
REQ-025 After each beat accepted in LOAD, idx SHALL decrement by 1, so indices are issued num-1 down to 0.
REQ-026 tap_valid SHALL be 0 in every cycle not following an accepted LOAD beat; a gap in s_valid therefore gives a gap in tap_valid.
REQ-027 tap_data and tap_count SHALL hold their last values while tap_valid=0.
REQ-028 When a beat is accepted in LOAD with idx = 0 and s_last = 1, the loader SHALL go to IDLE, and done SHALL pulse in the same cycle as the final tap_valid.
REQ-029 When a beat is accepted in LOAD with idx = 0 and s_last = 0, the loader SHALL issue that tap, set err, and go to DRAIN; there is no done pulse.
REQ-030 In DRAIN, the loader SHALL accept and discard beats with no tap_valid, and go to IDLE after accepting a beat with s_last = 1; there is no done pulse.
REQ-031 When a beat is accepted in LOAD with idx > 0 and s_last = 1, the loader SHALL issue that tap, set err, go to IDLE, and produce no done pulse.
REQ-032 err SHALL clear only on rst; a start accepted while err=1 SHALL still run normally.
REQ-033 num = MAX_TAPS SHALL give a first tap_count of MAX_TAPS-1 with no wrap; idx SHALL never decrement below 0.

Reset
REQ-034 With rst=1 at an edge, the block SHALL enter IDLE and set tap_valid, tap_data_r, tap_data_i, tap_count, done, err and idx to 0.
REQ-035 A reset during LOAD or DRAIN SHALL abort the load with no done pulse; s_ready SHALL be 0 in the cycle after the reset edge.
REQ-036 rst SHALL take priority over start and over the handshake at the same edge.

Verification
REQ-037 start with num=6, then 6 back-to-back beats carrying data_r 6,5,4,3,2,1 (data_i 0), s_last on the 6th -> tap_count 5,4,3,2,1,0 with matching data on consecutive cycles, each one cycle after its beat; done=1 with count 0; err=0.
REQ-038 num=4 with s_valid toggled 1,0,1,0,... -> tap_valid has the same gaps, the count sequence is 3,2,1,0, and done pulses once.
REQ-039 num=3 with s_last on the 2nd beat -> taps at counts 2 and 1 only, err=1, no done, busy=0 one cycle later.
REQ-040 num=2 with 4 beats and s_last on the 4th -> taps at counts 1 and 0, err=1, beats 3 and 4 consumed silently, then IDLE.
REQ-041 start with num=0, then start with num=33 -> err=1, busy stays 0; a following num=32 load issues a first tap_count of 31.
REQ-042 rst asserted after the 2nd beat of a num=6 load -> all outputs 0 next cycle and no done; a fresh num=6 load then completes normally.
